arbiter_rr16: RTL and testbench



---
 rtl/arbiter_rr16.sv | 76 +++++++
 tb/tb_arbiter_rr16.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/arbiter_rr16.sv
// Round-robin arbiter over N requesters with a one-hot grant and a binary
// index of the winner. Grants are combinational from `ready` and the
// registered priority pointer; the pointer moves past each winner so the
// last requester served becomes the lowest priority on the next cycle.
module arbiter_rr16 #(
  parameter int N = 16
) (
  input  logic         CLK,
  input  logic         RESET,
  input  logic [N-1:0] ready,
  output logic [N-1:0] grant,
  output logic [31:0]  granted
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;

  // Index of the requester scanned first this cycle.
  logic [PW-1:0] ptr;

  // Bits at or above the pointer form the high-priority window; when none
  // of them request, the scan wraps to the lowest set bit of `ready`.
  logic [N-1:0]  upper_mask;
  logic [N-1:0]  req_upper;
  logic          any_upper;
  logic          any_req;
  logic [31:0]   idx_upper;
  logic [31:0]   idx_all;

  genvar gi;
  generate
    for (gi = 0; gi < N; gi = gi + 1) begin : g_mask
      assign upper_mask[gi] = (PW'(gi) >= ptr);
    end
  endgenerate

  assign req_upper = ready & upper_mask;
  assign any_upper = |req_upper;
  assign any_req   = |ready;

  // Lowest set index inside the upper window and across the whole vector.
  always_comb begin
    idx_upper = 32'(N);
    idx_all   = 32'(N);
    for (int i = N - 1; i >= 0; i--) begin
      if (req_upper[i]) idx_upper = 32'(i);
      if (ready[i])     idx_all   = 32'(i);
    end
  end

  // Pick the winner and build the matching one-hot vector.
  always_comb begin
    grant = '0;
    if (any_upper) begin
      granted = idx_upper;
    end else begin
      granted = idx_all;
    end
    for (int i = 0; i < N; i++) begin
      if (any_req && (granted == 32'(i))) grant[i] = 1'b1;
    end
  end

  // Advance the pointer past the winner; hold it when nobody requests.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      ptr <= '0;
    end else if (any_req) begin
      if (granted == 32'(N - 1)) begin
        ptr <= '0;
      end else begin
        ptr <= PW'(granted + 32'd1);
      end
    end
  end

endmodule

// File: tb/tb_arbiter_rr16.sv
// Directed and model-checked stimulus for the 16-way round-robin arbiter.
module tb_arbiter_rr16;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic [15:0] ready = '0;
  logic [15:0] grant;
  logic [31:0] granted;

  int n_checks = 0;
  int n_pass = 0;

  arbiter_rr16 #(.N(16)) dut (
    .CLK    (CLK),
    .RESET  (RESET),
    .ready  (ready),
    .grant  (grant),
    .granted(granted)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
      $display("ok   %-14s got=%0h", tag, got);
    end else begin
      $display("FAIL %-14s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic expect_pair(input string tag, input logic [31:0] idx);
    logic [15:0] oh;
    oh = (idx == 32'd16) ? 16'h0000 : (16'h0001 << idx);
    check({tag, ".idx"}, granted, idx);
    check({tag, ".oh"}, {16'h0, grant}, {16'h0, oh});
  endtask

  task automatic do_reset();
    RESET = 1'b1;
    tick();
    RESET = 1'b0;
  endtask

  // Reference scan for the random section, written as the literal rotating search.
  function automatic logic [31:0] model_pick(input logic [15:0] r, input int p);
    for (int k = 0; k < 16; k++) begin
      if (r[(p + k) % 16]) return 32'((p + k) % 16);
    end
    return 32'd16;
  endfunction

  initial begin
    int m_ptr;
    logic [31:0] exp_idx;

    // Reset state and idle hold.
    ready = 16'h0000;
    tick();
    expect_pair("rst_idle", 32'd16);
    tick();
    RESET = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      expect_pair("idle", 32'd16);
    end

    // Two requesters alternate, first result visible before any edge.
    ready = 16'h0014;
    #1;
    expect_pair("t2_a", 32'd2);
    tick();
    expect_pair("t2_b", 32'd4);
    tick();
    expect_pair("t2_c", 32'd2);

    // Full rotation under all-requesting.
    do_reset();
    ready = 16'hFFFF;
    #1;
    for (int k = 0; k < 17; k++) begin
      expect_pair("t3_rot", 32'(k % 16));
      tick();
    end

    // Granting bit 15 wraps the pointer to 0.
    do_reset();
    ready = 16'h8000;
    #1;
    expect_pair("t4_15", 32'd15);
    tick();
    ready = 16'h8001;
    #1;
    expect_pair("t4_0", 32'd0);
    tick();
    expect_pair("t4_15b", 32'd15);

    // Wrap past bits 5..15 from ptr=5.
    do_reset();
    ready = 16'h0010;
    #1;
    expect_pair("t5_4", 32'd4);
    tick();
    ready = 16'h0009;
    #1;
    expect_pair("t5_wrap", 32'd0);
    tick();
    expect_pair("t5_3", 32'd3);

    // Mid-rotation reset returns priority to bit 0.
    do_reset();
    ready = 16'hFFFF;
    for (int i = 0; i < 9; i++) tick();
    expect_pair("t6_pre", 32'd9);
    RESET = 1'b1;
    #1;
    expect_pair("t6_inrst", 32'd9);
    tick();
    RESET = 1'b0;
    expect_pair("t6_post", 32'd0);

    // Random vectors against the reference scan, plus consistency.
    do_reset();
    m_ptr = 0;
    for (int t = 0; t < 60; t++) begin
      ready = (t % 7 == 3) ? 16'h0000 : 16'($urandom);
      #1;
      exp_idx = model_pick(ready, m_ptr);
      expect_pair("rand", exp_idx);
      check("rand_cons", {31'h0, (granted == 32'd16)}, {31'h0, (grant == 16'h0)});
      check("rand_subset", {16'h0, grant & ~ready}, 32'h0);
      if (exp_idx != 32'd16) m_ptr = (int'(exp_idx) + 1) % 16;
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
